vga_timing_gen: RTL and testbench

- Parametrised VGA timing generator for the dino game's VGA simulation harness and chip top.
- Produces pixel coordinates, sync pulses, blanking, a pixel-clock strobe and frame/line strobes.
- Timing values are generalised over any mode, with configurable sync polarity, a clock divider, run/freeze control, a synchronous restart and a frame counter.
- Replaces fixed 640x480 hard-coded counters so alternative modes can be built without editing RTL.

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/vga_timing_gen_pix_clk_div.sv | 44 ++++
 rtl/vga_timing_gen.sv | 135 +++++++++++++
 tb/tb_vga_timing_gen.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the parametrised VGA timing generator.
// Defaults describe 640x480@60 with a 25.175 MHz-class pixel clock.
package vga_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    typedef struct packed {
        logic pix;
        logic line;
        logic frame;
    } strobes_t;

    function automatic int unsigned total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sw, input int unsigned bp);
        return act + fp + sw + bp;
    endfunction

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_gen_pix_clk_div.sv
// Pixel clock divider: one step every CLK_DIV enabled clocks, plus a
// registered strobe that lines up with the counters it advanced.
module pix_clk_div
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clear,
    output logic step,
    output logic pix_stb
);

    localparam int unsigned DW = cnt_w(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic          pix_stb_q, pix_stb_d;

    assign step    = en & (div_q == DIV_LAST);
    assign pix_stb = pix_stb_q;

    always_comb begin
        div_d     = div_q;
        pix_stb_d = step & ~clear;
        if (clear)
            div_d = '0;
        else if (en)
            div_d = step ? '0 : div_q + DW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            pix_stb_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            pix_stb_q <= pix_stb_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA beam timing: coordinates, syncs, blanking and strobes,
// all registered from next-state counters so every output shares one edge.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter logic        HSYNC_POL = SYNC_ACTIVE_LOW,
    parameter logic        VSYNC_POL = SYNC_ACTIVE_LOW,
    parameter int unsigned CLK_DIV   = 1,
    parameter int unsigned FRAME_W   = 8,
    localparam int unsigned H_TOTAL  = total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int unsigned V_TOTAL  = total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int unsigned XW       = cnt_w(H_TOTAL),
    localparam int unsigned YW       = cnt_w(V_TOTAL)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               sync_clear,
    output logic [XW-1:0]      pix_x,
    output logic [YW-1:0]      pix_y,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic               pix_stb,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        CLK_DIV < 1 || FRAME_W < 1) begin : g_bad_params
        $error("vga_timing_gen: timing parameters must be nonzero and CLK_DIV >= 1");
    end

    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
    localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
    localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

    logic step;

    pix_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clear   (sync_clear),
        .step    (step),
        .pix_stb (pix_stb)
    );

    logic [XW-1:0]      pix_x_q, pix_x_d;
    logic [YW-1:0]      pix_y_q, pix_y_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               display_on_q, display_on_d;
    strobes_t           strb_q, strb_d;

    always_comb begin
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        frame_cnt_d = frame_cnt_q;
        strb_d      = '0;
        // A restart wins over any step landing on the same clock.
        if (sync_clear) begin
            pix_x_d = '0;
            pix_y_d = '0;
        end else if (step) begin
            strb_d.pix = 1'b1;
            if (pix_x_q == X_LAST) begin
                pix_x_d     = '0;
                strb_d.line = 1'b1;
                if (pix_y_q == Y_LAST) begin
                    pix_y_d      = '0;
                    strb_d.frame = 1'b1;
                    frame_cnt_d  = frame_cnt_q + FRAME_W'(1);
                end else begin
                    pix_y_d = pix_y_q + YW'(1);
                end
            end else begin
                pix_x_d = pix_x_q + XW'(1);
            end
        end
    end

    // Decode from the next-state counters so outputs register in step with them.
    always_comb begin
        hsync_d      = ((pix_x_d >= HS_START) && (pix_x_d < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d      = ((pix_y_d >= VS_START) && (pix_y_d < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
        display_on_d = en && (pix_x_d < X_ACT) && (pix_y_d < Y_ACT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            frame_cnt_q  <= '0;
            strb_q       <= '0;
            hsync_q      <= ~HSYNC_POL;
            vsync_q      <= ~VSYNC_POL;
            display_on_q <= 1'b0;
        end else begin
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            frame_cnt_q  <= frame_cnt_d;
            strb_q       <= strb_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            display_on_q <= display_on_d;
        end
    end

    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_cnt   = frame_cnt_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = display_on_q;
    assign line_start  = strb_q.line;
    assign frame_start = strb_q.frame;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: small 8x6 mode (CLK_DIV=2, FRAME_W=2) and default 640x480 mode,
// each checked every cycle against an arithmetic beam model.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic en_s, clr_s, en_d, clr_d;

    always #5 clk = ~clk;

    logic [2:0] s_x;  logic [2:0] s_y;  logic [1:0] s_fc;
    logic s_hs, s_vs, s_don, s_stb, s_ls, s_fs;
    logic [9:0] d_x;  logic [9:0] d_y;  logic [7:0] d_fc;
    logic d_hs, d_vs, d_don, d_stb, d_ls, d_fs;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(2), .FRAME_W(2)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en_s), .sync_clear(clr_s),
        .pix_x(s_x), .pix_y(s_y), .hsync(s_hs), .vsync(s_vs),
        .display_on(s_don), .pix_stb(s_stb), .line_start(s_ls),
        .frame_start(s_fs), .frame_cnt(s_fc)
    );

    vga_timing_gen dut_d (
        .clk(clk), .rst_n(rst_n), .en(en_d), .sync_clear(clr_d),
        .pix_x(d_x), .pix_y(d_y), .hsync(d_hs), .vsync(d_vs),
        .display_on(d_don), .pix_stb(d_stb), .line_start(d_ls),
        .frame_start(d_fs), .frame_cnt(d_fc)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Beam model: position is a pixel index advanced every d enabled clocks.
    typedef struct {
        int div, x, y, fc;
        bit stb, ls, fs, hs, vs, don;
    } m_t;

    function automatic m_t mreset(input bit hp, input bit vp);
        m_t r;
        r.div = 0; r.x = 0; r.y = 0; r.fc = 0;
        r.stb = 0; r.ls = 0; r.fs = 0; r.don = 0;
        r.hs = !hp; r.vs = !vp;
        return r;
    endfunction

    function automatic m_t mstep(input m_t s, input int ha, input int hf, input int hw, input int hb,
                                 input int va, input int vf, input int vw, input int vb,
                                 input int d, input int fw, input bit hp, input bit vp,
                                 input bit en, input bit clr);
        int ht = ha + hf + hw + hb;
        int vt = va + vf + vw + vb;
        m_t n = s;
        n.stb = 0; n.ls = 0; n.fs = 0;
        if (clr) begin
            n.div = 0; n.x = 0; n.y = 0;
        end else if (en) begin
            if (s.div == d - 1) begin
                n.div = 0;
                n.stb = 1;
                n.x = s.x + 1;
                if (n.x == ht) begin
                    n.x = 0; n.ls = 1; n.y = s.y + 1;
                    if (n.y == vt) begin
                        n.y = 0; n.fs = 1; n.fc = (s.fc + 1) % (1 << fw);
                    end
                end
            end else begin
                n.div = s.div + 1;
            end
        end
        n.hs  = (n.x >= ha + hf && n.x < ha + hf + hw) ? hp : !hp;
        n.vs  = (n.y >= va + vf && n.y < va + vf + vw) ? vp : !vp;
        n.don = en && n.x < ha && n.y < va;
        return n;
    endfunction

    m_t ms, md;
    bit cmp_on = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms <= mreset(0, 0);
            md <= mreset(0, 0);
        end else begin
            ms <= mstep(ms, 4, 1, 2, 1, 3, 1, 1, 1, 2, 2, 0, 0, en_s, clr_s);
            md <= mstep(md, 640, 16, 96, 48, 480, 10, 2, 33, 1, 8, 0, 0, en_d, clr_d);
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("s.pix_x", s_x, ms.x);         chk("s.pix_y", s_y, ms.y);
            chk("s.frame_cnt", s_fc, ms.fc);   chk("s.hsync", s_hs, ms.hs);
            chk("s.vsync", s_vs, ms.vs);       chk("s.display_on", s_don, ms.don);
            chk("s.pix_stb", s_stb, ms.stb);   chk("s.line_start", s_ls, ms.ls);
            chk("s.frame_start", s_fs, ms.fs);
            chk("d.pix_x", d_x, md.x);         chk("d.pix_y", d_y, md.y);
            chk("d.frame_cnt", d_fc, md.fc);   chk("d.hsync", d_hs, md.hs);
            chk("d.vsync", d_vs, md.vs);       chk("d.display_on", d_don, md.don);
            chk("d.pix_stb", d_stb, md.stb);   chk("d.line_start", d_ls, md.ls);
            chk("d.frame_start", d_fs, md.fs);
        end
    end

    initial begin
        int stb_n, fs_n, ls_n, don_n, hs_n, vs_n, hsd_n, lsd_n, tmo;
        int fc_seq[$];
        int exp_seq[5] = '{1, 2, 3, 0, 1};
        logic [1:0] fc_hold;

        rst_n = 1'b0;
        en_s = 1'b1; clr_s = 1'b0; en_d = 1'b1; clr_d = 1'b0;
        @(posedge clk);
        cmp_on = 1;
        repeat (3) @(negedge clk);
        chk("rst.pix_x", s_x, 0);        chk("rst.pix_y", s_y, 0);
        chk("rst.frame_cnt", s_fc, 0);   chk("rst.hsync", s_hs, 1);
        chk("rst.vsync", s_vs, 1);       chk("rst.display_on", s_don, 0);
        chk("rst.pix_stb", s_stb, 0);    chk("rst.line_start", s_ls, 0);
        chk("rst.frame_start", s_fs, 0); chk("rst.d_hsync", d_hs, 1);

        rst_n = 1'b1;
        stb_n = 0; fs_n = 0; ls_n = 0; don_n = 0; hs_n = 0; vs_n = 0; hsd_n = 0; lsd_n = 0;
        for (int k = 1; k <= 800; k++) begin
            @(negedge clk);
            if (k == 1) chk("first.pix_stb_k1", s_stb, 0);
            if (k == 2) begin chk("first.pix_stb_k2", s_stb, 1); chk("first.pix_x_k2", s_x, 1); end
            if (k == 16) begin
                chk("wrap.pix_x", s_x, 0); chk("wrap.pix_y", s_y, 1); chk("wrap.line_start", s_ls, 1);
            end
            if (k == 96) begin chk("frame1.frame_start", s_fs, 1); chk("frame1.frame_cnt", s_fc, 1); end
            if (k <= 480) begin
                stb_n += s_stb; fs_n += s_fs; ls_n += s_ls;
                don_n += s_don; hs_n += !s_hs; vs_n += !s_vs;
                if (s_fs) fc_seq.push_back(int'(s_fc));
            end
            hsd_n += !d_hs; lsd_n += d_ls;
        end
        chk("cnt.pix_stb", stb_n, 240);     chk("cnt.frame_start", fs_n, 5);
        chk("cnt.line_start", ls_n, 30);    chk("cnt.display_on_clk", don_n, 120);
        chk("cnt.hsync_clk", hs_n, 120);    chk("cnt.vsync_clk", vs_n, 80);
        chk("dflt.hsync_clk_per_line", hsd_n, 96);
        chk("dflt.line_start", lsd_n, 1);
        chk("fc_seq.len", fc_seq.size(), 5);
        for (int i = 0; i < 5 && i < fc_seq.size(); i++) chk("fc_seq", fc_seq[i], exp_seq[i]);

        // Freeze at pix_x=3 right after it was reached.
        tmo = 0;
        while (!(s_x == 3 && s_stb) && tmo < 100) begin @(negedge clk); tmo++; end
        chk("freeze.reach_timeout", tmo < 100, 1);
        en_s = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("freeze.pix_x", s_x, 3);         chk("freeze.display_on", s_don, 0);
            chk("freeze.pix_stb", s_stb, 0);     chk("freeze.line_start", s_ls, 0);
        end
        en_s = 1'b1;
        tmo = 0;
        do begin @(negedge clk); tmo++; end while (!s_stb && tmo < 10);
        chk("resume.pix_x", s_x, 4);

        // Restart while the step out of (6,2) is pending.
        tmo = 0;
        while (!(s_x == 6 && s_y == 2 && s_stb) && tmo < 200) begin @(negedge clk); tmo++; end
        chk("clear.reach_timeout", tmo < 200, 1);
        @(negedge clk);
        fc_hold = s_fc;
        clr_s = 1'b1;
        @(negedge clk);
        clr_s = 1'b0;
        chk("clear.pix_x", s_x, 0);   chk("clear.pix_y", s_y, 0);
        chk("clear.frame_cnt", s_fc, fc_hold);
        chk("clear.frame_start", s_fs, 0); chk("clear.pix_stb", s_stb, 0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            en_s  = ($urandom_range(0, 9) != 0);
            en_d  = ($urandom_range(0, 9) != 0);
            clr_s = ($urandom_range(0, 149) == 0);
            clr_d = ($urandom_range(0, 999) == 0);
        end

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst.pix_x", s_x, 0); chk("midrst.d_pix_x", d_x, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            en_s  = ($urandom_range(0, 5) != 0);
            en_d  = 1'b1;
            clr_s = ($urandom_range(0, 199) == 0);
            clr_d = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
